// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Parametrised matrix-keypad scanner. Drives one column at a time (one-hot,
//   active high) and samples the synchronised rows at the end of each column
//   dwell. After each full scan it debounces, accepts or releases a single key,
//   and can optionally auto-repeat.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   row_in       raw row lines (asynchronous), 1 = contact on the driven column
//   col_out      one-hot active-high column drive
//   key_code     linear index of the accepted key: col*N_ROWS + row
//   key_valid    one-cycle strobe: new press or auto-repeat
//   key_repeat   qualifies key_valid: 1 = auto-repeat event
//   key_release  one-cycle strobe when the held key is released
//   key_held     level: a key is accepted and not yet released
//   multi_key    level: last completed scan saw more than one closed contact
//
// Event semantics: key_valid, key_repeat and key_release are single-cycle
// strobes with no backpressure. A consumer must take them in the cycle they
// are high. key_repeat is only meaningful while key_valid is high. key_valid
// and key_release are never high in the same cycle.
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_RATE    = 8,
  localparam int CW            = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [CW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_repeat,
  output logic              key_release,
  output logic              key_held,
  output logic              multi_key
);

  localparam int DW     = $clog2(SCAN_DIV);
  localparam int COLW   = $clog2(N_COLS);
  localparam int RW     = $clog2(N_ROWS);
  localparam int DBW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW    = $clog2(RP_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_HELD     = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser
  // ---------------------------------------------------------------------------
  logic [N_ROWS-1:0] row_meta;
  logic [N_ROWS-1:0] row_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scanning and per-scan accumulation
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   dwell_cnt;
  logic [COLW-1:0] col_idx;
  logic [1:0]      acc_cnt;     // closed contacts so far, saturates at 2
  logic [CW-1:0]   acc_code;    // first closed index so far
  logic            scan_done;
  logic [1:0]      res_cnt;     // 0 = NONE, 1 = SINGLE, 2 = MULTI
  logic [CW-1:0]   res_code;

  logic            sample;
  logic            last_col;
  logic [1:0]      col_hits;
  logic [RW-1:0]   col_first_row;
  logic            col_found;
  logic [CW-1:0]   here_code;
  logic [2:0]      hit_sum;
  logic [1:0]      merged_cnt;
  logic [CW-1:0]   merged_code;

  assign sample   = (dwell_cnt == DW'(SCAN_DIV - 1));
  assign last_col = (col_idx == COLW'(N_COLS - 1));

  // Closed contacts on the currently driven column: count (sat. 2) and lowest row.
  always_comb begin
    col_hits      = 2'd0;
    col_first_row = '0;
    col_found     = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_sync[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        if (!col_found) begin
          col_found     = 1'b1;
          col_first_row = RW'(r);
        end
      end
    end
  end

  // Columns are visited in ascending order, so the first hit of the scan is
  // already the lowest index; later columns only add to the count.
  always_comb begin
    here_code   = CW'(int'(col_idx) * N_ROWS + int'(col_first_row));
    hit_sum     = {1'b0, acc_cnt} + {1'b0, col_hits};
    merged_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    merged_code = (acc_cnt == 2'd0) ? here_code : acc_code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col_out   <= N_COLS'(1);
      acc_cnt   <= 2'd0;
      acc_code  <= '0;
      scan_done <= 1'b0;
      res_cnt   <= 2'd0;
      res_code  <= '0;
    end else begin
      scan_done <= 1'b0;
      if (sample) begin
        dwell_cnt <= '0;
        col_out   <= {col_out[N_COLS-2:0], col_out[N_COLS-1]};
        if (last_col) begin
          col_idx   <= '0;
          acc_cnt   <= 2'd0;
          acc_code  <= '0;
          scan_done <= 1'b1;
          res_cnt   <= merged_cnt;
          res_code  <= merged_code;
        end else begin
          col_idx  <= col_idx + 1'b1;
          acc_cnt  <= merged_cnt;
          acc_code <= merged_code;
        end
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat counter advance (one held scan). First event after
  // REPEAT_DELAY held scans, then every REPEAT_RATE held scans.
  // ---------------------------------------------------------------------------
  logic [RPW-1:0] rep_cnt;
  logic           rep_phase;    // 0: waiting for first repeat, 1: periodic
  logic [RPW-1:0] rep_adv;
  logic           phase_adv;
  logic           rep_fire;

  always_comb begin
    rep_adv   = rep_cnt;
    phase_adv = rep_phase;
    rep_fire  = 1'b0;
    if (REPEAT_DELAY > 0) begin
      if (!rep_phase) begin
        if (int'(rep_cnt) + 1 >= REPEAT_DELAY) begin
          rep_fire  = 1'b1;
          phase_adv = 1'b1;
          rep_adv   = '0;
        end else begin
          rep_adv = rep_cnt + 1'b1;
        end
      end else if (int'(rep_cnt) + 1 >= REPEAT_RATE) begin
        rep_fire = 1'b1;
        rep_adv  = '0;
      end else begin
        rep_adv = rep_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce / hold FSM, advances only on scan_done
  // ---------------------------------------------------------------------------
  state_t         state, state_n;
  logic [DBW-1:0] db_cnt, db_n;
  logic [CW-1:0]  cand, cand_n;
  logic [RPW-1:0] rep_n;
  logic           phase_n;
  logic [CW-1:0]  code_n;
  logic           held_n, multi_n, valid_n, repeat_n, release_n;
  logic           res_none, res_single;

  assign res_none   = (res_cnt == 2'd0);
  assign res_single = (res_cnt == 2'd1);

  always_comb begin
    state_n   = state;
    db_n      = db_cnt;
    cand_n    = cand;
    rep_n     = rep_cnt;
    phase_n   = rep_phase;
    code_n    = key_code;
    held_n    = key_held;
    multi_n   = multi_key;
    valid_n   = 1'b0;
    repeat_n  = 1'b0;
    release_n = 1'b0;
    if (scan_done) begin
      multi_n = (res_cnt == 2'd2);
      unique case (state)
        S_IDLE: begin
          if (res_single) begin
            cand_n = res_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_n = S_HELD;
              code_n  = res_code;
              valid_n = 1'b1;
              held_n  = 1'b1;
              db_n    = '0;
              rep_n   = '0;
              phase_n = 1'b0;
            end else begin
              state_n = S_PRESS_DB;
              db_n    = DBW'(1);
            end
          end
        end
        S_PRESS_DB: begin
          if (res_single) begin
            if (res_code == cand) begin
              if (int'(db_cnt) + 1 >= DEBOUNCE_SCANS) begin
                state_n = S_HELD;
                code_n  = cand;
                valid_n = 1'b1;
                held_n  = 1'b1;
                db_n    = '0;
                rep_n   = '0;
                phase_n = 1'b0;
              end else begin
                db_n = db_cnt + 1'b1;
              end
            end else begin
              cand_n = res_code;
              db_n   = DBW'(1);
            end
          end else begin
            state_n = S_IDLE;
            db_n    = '0;
          end
        end
        S_HELD: begin
          if (res_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n   = S_IDLE;
              release_n = 1'b1;
              held_n    = 1'b0;
              db_n      = '0;
            end else begin
              state_n = S_REL_DB;
              db_n    = DBW'(1);
            end
          end else begin
            // Any contact (same key, other key or several) counts as held.
            rep_n    = rep_adv;
            phase_n  = phase_adv;
            valid_n  = rep_fire;
            repeat_n = rep_fire;
          end
        end
        S_REL_DB: begin
          if (res_none) begin
            if (int'(db_cnt) + 1 >= DEBOUNCE_SCANS) begin
              state_n   = S_IDLE;
              release_n = 1'b1;
              held_n    = 1'b0;
              db_n      = '0;
            end else begin
              db_n = db_cnt + 1'b1;
            end
          end else begin
            // Release glitch: resume holding; the repeat count carries on.
            state_n  = S_HELD;
            db_n     = '0;
            rep_n    = rep_adv;
            phase_n  = phase_adv;
            valid_n  = rep_fire;
            repeat_n = rep_fire;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      db_cnt      <= '0;
      cand        <= '0;
      rep_cnt     <= '0;
      rep_phase   <= 1'b0;
      key_code    <= '0;
      key_held    <= 1'b0;
      multi_key   <= 1'b0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      db_cnt      <= db_n;
      cand        <= cand_n;
      rep_cnt     <= rep_n;
      rep_phase   <= phase_n;
      key_code    <= code_n;
      key_held    <= held_n;
      multi_key   <= multi_n;
      key_valid   <= valid_n;
      key_repeat  <= repeat_n;
      key_release <= release_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Two scanner instances share clk/rst: dut_a without auto-repeat and dut_b
//   with REPEAT_DELAY = 4, REPEAT_RATE = 2. Each has its own key matrix that
//   is turned into row_in from its col_out. Key sets change only on scan
//   boundaries, and a scan-level reference model predicts every output at
//   every negedge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int DB    = 3;
  localparam int DLY_B = 4;
  localparam int RATE_B = 2;
  localparam logic [12:0] RST_OBS = 13'b0001_0000_00000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n;   // posedges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // ---------------------------------------------------------------------------
  // DUTs and key matrices
  // ---------------------------------------------------------------------------
  logic [15:0] keys [2];
  logic [3:0]  row_a, row_b, col_out_a, col_out_b, key_code_a, key_code_b;
  logic        key_valid_a, key_repeat_a, key_release_a, key_held_a, multi_key_a;
  logic        key_valid_b, key_repeat_b, key_release_b, key_held_b, multi_key_b;

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY(0), .REPEAT_RATE(8)
  ) dut_a (
    .clk(clk), .rst(rst), .row_in(row_a), .col_out(col_out_a),
    .key_code(key_code_a), .key_valid(key_valid_a), .key_repeat(key_repeat_a),
    .key_release(key_release_a), .key_held(key_held_a), .multi_key(multi_key_a)
  );

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY(DLY_B), .REPEAT_RATE(RATE_B)
  ) dut_b (
    .clk(clk), .rst(rst), .row_in(row_b), .col_out(col_out_b),
    .key_code(key_code_b), .key_valid(key_valid_b), .key_repeat(key_repeat_b),
    .key_release(key_release_b), .key_held(key_held_b), .multi_key(multi_key_b)
  );

  // A closed key at index c*4+r connects column c to row r.
  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (col_out_a[c] && keys[0][c*4+r]) row_a[r] = 1'b1;
        if (col_out_b[c] && keys[1][c*4+r]) row_b[r] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [12:0] obs(input int i);
    if (i == 0)
      return {col_out_a, key_code_a, key_valid_a, key_repeat_a, key_release_a, key_held_a, multi_key_a};
    return {col_out_b, key_code_b, key_valid_b, key_repeat_b, key_release_b, key_held_b, multi_key_b};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: one step per completed scan, from the set of closed keys
  // ---------------------------------------------------------------------------
  logic       m_held [2];
  logic [3:0] m_code [2];
  logic       m_multi [2];
  int         m_run_code [2];
  int         m_run_len [2];
  int         m_none_run [2];
  int         m_held_scans [2];
  logic       e_valid [2];
  logic       e_rep [2];
  logic       e_rel [2];
  logic [15:0] mid_keys [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 0; m_code[i] = 0; m_multi[i] = 0;
      m_run_code[i] = -1; m_run_len[i] = 0; m_none_run[i] = 0; m_held_scans[i] = 0;
      e_valid[i] = 0; e_rep[i] = 0; e_rel[i] = 0;
    end
  endtask

  task automatic model_scan(input int i, input logic [15:0] k);
    int nk;
    int first;
    int d;
    nk = $countones(k);
    first = -1;
    for (int b = 15; b >= 0; b--) if (k[b]) first = b;   // lowest index = lowest col, then row
    d = (i == 0) ? 0 : DLY_B;
    m_multi[i] = (nk > 1);
    if (!m_held[i]) begin
      if (nk == 1) begin
        if (m_run_len[i] > 0 && m_run_code[i] == first) m_run_len[i]++;
        else begin
          m_run_code[i] = first;
          m_run_len[i] = 1;
        end
        if (m_run_len[i] == DB) begin
          m_held[i] = 1;
          m_code[i] = 4'(first);
          e_valid[i] = 1;
          m_held_scans[i] = 0;
          m_none_run[i] = 0;
          m_run_len[i] = 0;
        end
      end else begin
        m_run_len[i] = 0;
      end
    end else if (nk == 0) begin
      m_none_run[i]++;
      if (m_none_run[i] == DB) begin
        m_held[i] = 0;
        e_rel[i] = 1;
        m_run_len[i] = 0;
      end
    end else begin
      m_none_run[i] = 0;
      m_held_scans[i]++;
      if (d > 0 && m_held_scans[i] >= d && (m_held_scans[i] - d) % RATE_B == 0) begin
        e_valid[i] = 1;
        e_rep[i] = 1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: compare every output of both instances at every negedge
  // ---------------------------------------------------------------------------
  int va_cnt [2] = '{0, 0};
  int rp_cnt [2] = '{0, 0};
  int rl_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (!rst) begin
      if (n % 32 == 16) begin
        mid_keys[0] = keys[0];
        mid_keys[1] = keys[1];
      end
      for (int i = 0; i < 2; i++) begin
        e_valid[i] = 0; e_rep[i] = 0; e_rel[i] = 0;
        if (n % 32 == 1 && n > 32) model_scan(i, mid_keys[i]);
        check((i == 0) ? "outs_a" : "outs_b", 32'(obs(i)),
              32'({4'(1 << ((n / 8) % 4)), m_code[i], e_valid[i], e_rep[i], e_rel[i],
                   m_held[i], m_multi[i]}));
      end
      if (key_valid_a)   va_cnt[0]++;
      if (key_repeat_a)  rp_cnt[0]++;
      if (key_release_a) rl_cnt[0]++;
      if (key_valid_b)   va_cnt[1]++;
      if (key_repeat_b)  rp_cnt[1]++;
      if (key_release_b) rl_cnt[1]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Called on a scan boundary: set both matrices for one full scan and return
  // on the next boundary.
  task automatic scan(input logic [15:0] ka, input logic [15:0] kb);
    int guard;
    keys[0] = ka;
    keys[1] = kb;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (n % 32 != 0 && guard < 64);
    if (guard >= 64) check("scan_boundary_timeout", 32'(guard), 32'd32);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_keys(input logic [15:0] prev);
    int sel;
    int a;
    int b;
    sel = int'($urandom_range(0, 9));
    if (sel < 4) return prev;
    if (sel < 6) return 16'h0000;
    a = int'($urandom_range(0, 15));
    if (sel < 9) return 16'(1) << a;
    b = (a + int'($urandom_range(1, 15))) % 16;
    return (16'(1) << a) | (16'(1) << b);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base_v;
    int base_r;
    int base_p;
    logic [15:0] ra;
    logic [15:0] rb;

    keys[0] = '0;
    keys[1] = '0;
    mid_keys[0] = '0;
    mid_keys[1] = '0;
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_a", 32'(obs(0)), 32'(RST_OBS));
    check("rst_b", 32'(obs(1)), 32'(RST_OBS));
    release_reset();

    // 1: no keys, columns rotate, nothing else moves
    repeat (2) scan(16'h0000, 16'h0000);

    // 2: key 9 (col 2 / row 1) for 5 scans, then open
    base_v = va_cnt[0]; base_r = rl_cnt[0];
    repeat (5) scan(16'h0200, 16'h0000);
    repeat (4) scan(16'h0000, 16'h0000);
    check("t2_valid_cnt", 32'(va_cnt[0] - base_v), 32'd1);
    check("t2_release_cnt", 32'(rl_cnt[0] - base_r), 32'd1);
    check("t2_code", 32'(key_code_a), 32'd9);
    check("t2_held", 32'(key_held_a), 32'd0);

    // 3: bounce before the press, then a one-scan glitch while held (key 6)
    base_v = va_cnt[0]; base_r = rl_cnt[0];
    repeat (2) scan(16'h0040, 16'h0000);
    scan(16'h0000, 16'h0000);
    repeat (3) scan(16'h0040, 16'h0000);
    scan(16'h0000, 16'h0000);
    repeat (2) scan(16'h0040, 16'h0000);
    check("t3_valid_cnt", 32'(va_cnt[0] - base_v), 32'd1);
    check("t3_glitch_no_release", 32'(rl_cnt[0] - base_r), 32'd0);
    check("t3_held", 32'(key_held_a), 32'd1);
    repeat (4) scan(16'h0000, 16'h0000);
    check("t3_release_cnt", 32'(rl_cnt[0] - base_r), 32'd1);

    // 4: keys 0 and 15 together, then key 15 opens
    base_v = va_cnt[0];
    repeat (2) scan(16'h8001, 16'h0000);
    scan(16'h0001, 16'h0000);
    check("t4_multi", 32'(multi_key_a), 32'd1);
    check("t4_no_valid", 32'(va_cnt[0] - base_v), 32'd0);
    scan(16'h0001, 16'h0000);
    check("t4_multi_clear", 32'(multi_key_a), 32'd0);
    repeat (2) scan(16'h0001, 16'h0000);
    check("t4_valid_cnt", 32'(va_cnt[0] - base_v), 32'd1);
    check("t4_code", 32'(key_code_a), 32'd0);
    repeat (4) scan(16'h0000, 16'h0000);

    // 5: auto-repeat on dut_b, key 5 held through press + 12 scans
    base_v = va_cnt[1]; base_p = rp_cnt[1]; base_r = rl_cnt[1];
    repeat (15) scan(16'h0000, 16'h0020);
    repeat (4) scan(16'h0000, 16'h0000);
    check("t5_valid_cnt", 32'(va_cnt[1] - base_v), 32'd6);
    check("t5_repeat_cnt", 32'(rp_cnt[1] - base_p), 32'd5);
    check("t5_release_cnt", 32'(rl_cnt[1] - base_r), 32'd1);
    check("t5_code", 32'(key_code_b), 32'd5);

    // 6: reset while holding key 7, key stays closed through and after reset
    base_v = va_cnt[0];
    repeat (4) scan(16'h0080, 16'h0000);
    check("t6_first_press", 32'(va_cnt[0] - base_v), 32'd1);
    repeat (5) @(negedge clk);
    base_v = va_cnt[0]; base_r = rl_cnt[0];
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_a", 32'(obs(0)), 32'(RST_OBS));
    check("t6_rst_b", 32'(obs(1)), 32'(RST_OBS));
    release_reset();
    repeat (4) scan(16'h0080, 16'h0000);
    check("t6_fresh_press", 32'(va_cnt[0] - base_v), 32'd1);
    check("t6_code", 32'(key_code_a), 32'd7);
    check("t6_no_release", 32'(rl_cnt[0] - base_r), 32'd0);
    repeat (4) scan(16'h0000, 16'h0000);

    // Random key traffic on both instances
    ra = '0;
    rb = '0;
    for (int s = 0; s < 100; s++) begin
      ra = rand_keys(ra);
      rb = rand_keys(rb);
      scan(ra, rb);
    end
    repeat (5) scan(16'h0000, 16'h0000);
    check("end_idle_a", 32'(key_held_a), 32'd0);
    check("end_idle_b", 32'(key_held_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
